// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and interrupt-entry control.
// Load-use stall, branch/jump flush, interrupt FSM, stall counter.
module hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int XP    = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_eret,
    input  logic             ex_mem_rd,
    input  logic [4:0]       ex_addr,
    input  logic             ex_branch_taken,
    input  logic             irq,
    input  logic             kernel,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             irq_take,
    output logic             irq_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // XP is the register the datapath writes the return PC into.
    if (XP < 1 || XP > 31) begin : g_xp_chk
        $error("hazard_ctrl: XP must name a register in 1..31");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_TAKE,
        S_MASK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic w_rs_hit;
    logic w_rt_hit;
    logic w_load_use;
    logic w_in_take;
    logic w_stall;
    logic w_irq_req;
    logic w_irq_ok;
    logic w_hold_pc;
    logic w_hold_ifid;
    logic w_flush_ifid;
    logic w_flush_idex;
    logic w_irq_take;

    assign w_rs_hit   = (ex_addr == id_rs);
    assign w_rt_hit   = id_uses_rt && (ex_addr == id_rt);
    assign w_load_use = ex_mem_rd && (ex_addr != 5'd0)
                        && (w_rs_hit || w_rt_hit);

    assign w_in_take  = (r_state == S_TAKE);

    // A stall cycle is one where the load-use bubble really is inserted.
    assign w_stall    = !reset && !w_in_take && !ex_branch_taken
                        && w_load_use;

    // User-mode request, and whether the pipeline can accept it now.
    assign w_irq_req  = irq && !kernel;
    assign w_irq_ok   = w_irq_req && !ex_branch_taken && !w_load_use;

    // Pipeline control, priority: TAKE, taken branch, load-use, jump.
    always_comb begin
        w_hold_pc    = 1'b0;
        w_hold_ifid  = 1'b0;
        w_flush_ifid = 1'b0;
        w_flush_idex = 1'b0;
        w_irq_take   = 1'b0;
        if (reset) begin
            w_irq_take = 1'b0;
        end else if (w_in_take) begin
            w_irq_take   = 1'b1;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end else if (ex_branch_taken) begin
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
        end else if (w_load_use) begin
            w_hold_pc    = 1'b1;
            w_hold_ifid  = 1'b1;
            w_flush_idex = 1'b1;
        end else if (id_jump) begin
            w_flush_ifid = 1'b1;
        end
    end

    // Interrupt entry FSM; irq_busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_irq_req) begin
                        r_state <= w_irq_ok ? S_TAKE : S_PEND;
                    end
                end
                S_PEND: begin
                    if (!irq) begin
                        r_state <= S_IDLE;
                    end else if (w_irq_ok) begin
                        r_state <= S_TAKE;
                    end
                end
                S_TAKE: begin
                    r_state <= S_MASK;
                    r_busy  <= 1'b1;
                end
                S_MASK: begin
                    if (id_eret && !w_hold_ifid) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign hold_pc    = w_hold_pc;
    assign hold_ifid  = w_hold_ifid;
    assign flush_ifid = w_flush_ifid;
    assign flush_idex = w_flush_idex;
    assign irq_take   = w_irq_take;
    assign irq_busy   = r_busy;
    assign stall_cnt  = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl.
// Expected outputs are queued per driven cycle and checked at negedge.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             id_eret;
    logic             ex_mem_rd;
    logic [4:0]       ex_addr;
    logic             ex_branch_taken;
    logic             irq;
    logic             kernel;
    logic             hold_pc;
    logic             hold_ifid;
    logic             flush_ifid;
    logic             flush_idex;
    logic             irq_take;
    logic             irq_busy;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .XP(26)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .id_eret         (id_eret),
        .ex_mem_rd       (ex_mem_rd),
        .ex_addr         (ex_addr),
        .ex_branch_taken (ex_branch_taken),
        .irq             (irq),
        .kernel          (kernel),
        .hold_pc         (hold_pc),
        .hold_ifid       (hold_ifid),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .irq_take        (irq_take),
        .irq_busy        (irq_busy),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             hp;
        logic             hi;
        logic             fi;
        logic             fe;
        logic             it;
        logic             ib;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    // model state: 0 idle, 1 pend, 2 take, 3 mask
    int               m_st = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_lu();
        return ex_mem_rd && (ex_addr != 5'd0) &&
               ((ex_addr == id_rs) || (id_uses_rt && (ex_addr == id_rt)));
    endfunction

    task automatic push_exp();
        exp_t e;
        logic lu;
        lu = m_lu();
        e  = '0;
        if (!reset) begin
            if (m_st == 2) begin
                e.it = 1'b1; e.fi = 1'b1; e.fe = 1'b1;
            end else if (ex_branch_taken) begin
                e.fi = 1'b1; e.fe = 1'b1;
            end else if (lu) begin
                e.hp = 1'b1; e.hi = 1'b1; e.fe = 1'b1;
            end else if (id_jump) begin
                e.fi = 1'b1;
            end
        end
        e.ib  = (m_st == 3);
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic m_clock();
        logic lu;
        logic stall;
        logic ok;
        lu = m_lu();
        if (reset) begin
            m_st  = 0;
            m_cnt = '0;
        end else begin
            stall = lu && !ex_branch_taken && (m_st != 2);
            ok    = irq && !kernel && !ex_branch_taken && !lu;
            if (stall && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
            case (m_st)
                0: if (irq && !kernel) m_st = ok ? 2 : 1;
                1: if (!irq) m_st = 0; else if (ok) m_st = 2;
                2: m_st = 3;
                3: if (id_eret && !stall) m_st = 0;
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        push_exp();
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, ".sb"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".hold_pc"},    32'(hold_pc),    32'(e.hp));
            chk({tag, ".hold_ifid"},  32'(hold_ifid),  32'(e.hi));
            chk({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(e.fi));
            chk({tag, ".flush_idex"}, 32'(flush_idex), 32'(e.fe));
            chk({tag, ".irq_take"},   32'(irq_take),   32'(e.it));
            chk({tag, ".irq_busy"},   32'(irq_busy),   32'(e.ib));
            chk({tag, ".stall_cnt"},  32'(stall_cnt),  32'(e.cnt));
        end
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_jump = 1'b0; id_eret = 1'b0; ex_mem_rd = 1'b0;
        ex_addr = 5'd0; ex_branch_taken = 1'b0;
        irq = 1'b0; kernel = 1'b0;
    endtask

    task automatic set_lu();
        ex_mem_rd = 1'b1; ex_addr = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clk);
        #1;
        // outputs quiet under reset even with every event requested
        set_lu(); id_jump = 1'b1; ex_branch_taken = 1'b1; irq = 1'b1;
        step("rst");
        reset = 1'b0;
        clr(); step("idle");

        // load-use on rs
        set_lu(); step("lu_rs");
        clr(); step("lu_after");

        // no false hazards
        ex_mem_rd = 1'b1; ex_addr = 5'd0; id_rs = 5'd0; step("r0");
        ex_addr = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        step("rt_unused");
        id_uses_rt = 1'b1; step("lu_rt");
        ex_mem_rd = 1'b0; step("noload");
        clr(); id_jump = 1'b1; step("jump");
        set_lu(); step("jump_lu");
        clr(); set_lu(); ex_branch_taken = 1'b1; id_jump = 1'b1;
        step("br_lu");
        clr(); step("idle2");

        // irq held off by load-use, then serviced once
        set_lu(); irq = 1'b1; step("irq_lu");
        clr(); irq = 1'b1; step("pend");
        step("take");
        step("mask1");
        step("mask2");
        set_lu(); id_eret = 1'b1; step("eret_held");
        clr(); irq = 1'b1; id_eret = 1'b1; step("eret");
        irq = 1'b0; id_eret = 1'b0; step("after_eret");

        // kernel requests ignored, pending request withdrawn
        irq = 1'b1; kernel = 1'b1; step("kernel");
        kernel = 1'b0; ex_branch_taken = 1'b1; step("pend_br");
        clr(); step("pend_drop");
        id_eret = 1'b1; step("eret_idle");

        // TAKE overrides branch and jump
        clr(); irq = 1'b1; step("irq_go");
        irq = 1'b0; ex_branch_taken = 1'b1; id_jump = 1'b1;
        step("take_br");
        clr(); step("mask3");
        id_eret = 1'b1; step("eret2");

        // reset during TAKE
        clr(); irq = 1'b1; step("irq_go2");
        irq = 1'b0; reset = 1'b1; step("rst_take");
        reset = 1'b0; step("post_rst");

        // saturation
        set_lu();
        while (m_cnt != 16'hFFFE) step("sat");
        step("sat1");
        step("sat2");
        step("sat3");
        clr(); step("sat_hold");

        // reset during MASK
        irq = 1'b1; step("irq_go3");
        irq = 1'b0; step("take3");
        reset = 1'b1; step("rst_mask");
        reset = 1'b0; step("post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters:
- CNT_W, default 16, width of the stall performance counter.
- XP, default 26, exception-PC register number.

REQ-002 Ports (one per line):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- id_jump  in  1  ID holds j/jal/jr/jalr.
- id_eret  in  1  ID holds exception-return instruction.
- ex_mem_rd  in  1  EX holds a load.
- ex_addr  in  5  EX destination register (reg_dst-resolved).
- ex_branch_taken  in  1  EX branch resolved taken.
- irq  in  1  level interrupt request.
- kernel  in  1  PC[31] of ID instruction (supervisor mode).
- hold_pc  out  1  PC register keeps its value.
- hold_ifid  out  1  IF/ID register keeps its value.
- flush_ifid  out  1  IF/ID loads a NOP.
- flush_idex  out  1  ID/EX loads a bubble (all write/mem controls 0).
- irq_take  out  1  PC <- interrupt vector; write PC+4 of ID instruction to reg XP.
- irq_busy  out  1  interrupt in service (state MASK).
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-003 load_use SHALL be 1 iff ex_mem_rd=1, ex_addr!=0, and either (ex_addr==id_rs) or (ex_addr==id_rt and id_uses_rt=1).
REQ-004 Branch: ex_branch_taken=1 SHALL assert flush_ifid=1 and flush_idex=1 in the same cycle, with hold_pc=0 and hold_ifid=0; load_use is ignored that cycle.
REQ-005 Load-use: load_use=1 without a taken branch SHALL assert hold_pc=1, hold_ifid=1 and flush_idex=1 in the same cycle, for exactly one cycle per load, giving 1-cycle stall latency.
REQ-006 Jump: id_jump=1 without a taken branch or load_use SHALL assert flush_ifid=1 only.
REQ-007 Outputs in REQ-003..006 SHALL be combinational from inputs and state; irq_busy and stall_cnt SHALL be registered.
REQ-008 The FSM SHALL have states IDLE, PEND, TAKE and MASK.
REQ-009 Transition IDLE or PEND -> TAKE when irq=1, kernel=0, ex_branch_taken=0 and load_use=0.
REQ-010 Transition IDLE -> PEND when irq=1 and kernel=0 but a branch or load_use blocks entry.
REQ-011 PEND SHALL return to IDLE if irq drops before entry.
REQ-012 Requests with kernel=1 SHALL be ignored; the FSM stays in IDLE.
REQ-013 TAKE SHALL last exactly one cycle and drive irq_take=1, flush_ifid=1, flush_idex=1, hold_pc=0; the next state is MASK unconditionally.
REQ-014 MASK SHALL drive irq_busy=1 and ignore irq; id_eret=1 with hold_ifid=0 SHALL transition it to IDLE.
REQ-015 An id_eret in IDLE or PEND SHALL have no FSM effect.
REQ-016 Priority of simultaneous events, highest first: TAKE state, taken branch, load_use, jump.
REQ-017 stall_cnt SHALL increment by 1 on each cycle with load_use=1 and no taken branch, and saturate at all-ones without wrapping.
REQ-018 The block SHALL contain no combinational path from irq_take back to any of its own inputs.

Reset
REQ-019 With reset=1 sampled at a rising clk edge, the next state SHALL be IDLE, irq_busy SHALL be 0 and stall_cnt SHALL be 0.
REQ-020 While reset=1, hold_pc, hold_ifid, flush_ifid, flush_idex and irq_take SHALL all be 0.
REQ-021 Reset asserted in TAKE or MASK SHALL abandon service with no further irq_take.

Verification
REQ-022 Load-use: ex_mem_rd=1, ex_addr=8, id_rs=8 for 1 cycle -> hold_pc=hold_ifid=flush_idex=1 for 1 cycle; stall_cnt 0->1.
REQ-023 No false hazards: ex_addr=0 with id_rs=0, and ex_addr=9, id_rt=9, id_uses_rt=0 -> no hold or flush, stall_cnt unchanged.
REQ-024 Branch plus load_use in the same cycle -> flush_ifid=flush_idex=1, hold_pc=0, stall_cnt unchanged.
REQ-025 Interrupt held off by load_use: irq=1, kernel=0 during load_use -> PEND for 1 cycle, then irq_take=1 for exactly 1 cycle, then irq_busy=1; irq held high -> no second take until id_eret, then IDLE.
REQ-026 Saturation and reset: preload stall_cnt to 0xFFFE (CNT_W=16), apply 3 load-use cycles -> 0xFFFF held; reset=1 in MASK -> next cycle irq_busy=0, stall_cnt=0.
